// File: rtl/rot_pkg.sv
// Shared widths, matrix/CORDIC field offsets and saturating negate for the rotation-matrix feeder.
package rot_pkg;

  localparam int unsigned W = 32;

  localparam int unsigned MAT_M00 = 3 * W;
  localparam int unsigned MAT_M01 = 2 * W;
  localparam int unsigned MAT_M10 = 1 * W;
  localparam int unsigned MAT_M11 = 0;

  localparam int unsigned DOUT_COS = W;
  localparam int unsigned DOUT_SIN = 0;

  // -x, except the most negative value clamps to the most positive one
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
    if (x == {1'b1, {(W-1){1'b0}}}) begin
      return {1'b0, {(W-1){1'b1}}};
    end
    return W'(~x + W'(1));
  endfunction

endpackage

// File: rtl/rot_fifo.sv
// Register FIFO holding captured {cos,sin} words; DEPTH must be a power of two.
module rot_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  // A push at full is legal only when the same cycle frees the head slot
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rot_matrix_feeder.sv
// Issues phases to the CORDIC against buffer credits, captures cos/sin results and
// presents the packed 2x2 rotation matrix to the multiplier with valid/ready.
module rot_matrix_feeder
  import rot_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_valid,
  output logic             phase_ready,
  input  logic [W-1:0]     phase_data,
  output logic             cordic_phase_tvalid,
  output logic [W-1:0]     cordic_phase_tdata,
  input  logic             cordic_dout_tvalid,
  input  logic [2*W-1:0]   cordic_dout_tdata,
  output logic             mat_valid,
  input  logic             mat_ready,
  output logic [4*W-1:0]   mat_A,
  output logic             err_spurious
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  occ_d;
  logic           phase_ready_q, phase_ready_d;
  logic           tvalid_q, tvalid_d;
  logic [W-1:0]   tdata_q, tdata_d;
  logic           err_q, err_d;

  logic           accept, capture, push, pop;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [2*W-1:0] head;
  logic [W-1:0]   head_cos, head_sin;

  rot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (2 * W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cordic_dout_tdata),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credit bookkeeping: ready looks at next-state counts so an accept is never double-booked
  always_comb begin
    accept     = phase_valid && phase_ready_q;
    capture    = cordic_dout_tvalid && (inflight_q != '0);
    pop        = !fifo_empty && mat_ready;
    push       = capture && (!fifo_full || pop);
    inflight_d = inflight_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    occ_d = fifo_count;
    case ({push, pop})
      2'b10:   occ_d = fifo_count + CW'(1);
      2'b01:   occ_d = fifo_count - CW'(1);
      default: occ_d = fifo_count;
    endcase
    phase_ready_d = (SW'(inflight_d) + SW'(occ_d)) < SW'(FIFO_DEPTH);
    tvalid_d      = accept;
    tdata_d       = accept ? phase_data : tdata_q;
    err_d         = err_q || (cordic_dout_tvalid && (inflight_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= '0;
      phase_ready_q <= 1'b0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      phase_ready_q <= phase_ready_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      err_q         <= err_d;
    end
  end

  // Matrix {cos, -sin, sin, cos} built from the FIFO head
  always_comb begin
    head_cos               = head[DOUT_COS +: W];
    head_sin               = head[DOUT_SIN +: W];
    mat_A                  = '0;
    mat_A[MAT_M00 +: W]    = head_cos;
    mat_A[MAT_M01 +: W]    = sat_neg(head_sin);
    mat_A[MAT_M10 +: W]    = head_sin;
    mat_A[MAT_M11 +: W]    = head_cos;
  end

  assign phase_ready         = phase_ready_q;
  assign cordic_phase_tvalid = tvalid_q;
  assign cordic_phase_tdata  = tdata_q;
  assign mat_valid           = !fifo_empty;
  assign err_spurious        = err_q;

endmodule

// File: tb/tb_rot_matrix_feeder.sv
// Directed bench for rot_matrix_feeder: reset, single issue, backpressure, saturation,
// concurrent accept/capture/pop and spurious-result handling.
module tb_rot_matrix_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         phase_valid;
  logic         phase_ready;
  logic [31:0]  phase_data;
  logic         cordic_phase_tvalid;
  logic [31:0]  cordic_phase_tdata;
  logic         cordic_dout_tvalid;
  logic [63:0]  cordic_dout_tdata;
  logic         mat_valid;
  logic         mat_ready;
  logic [127:0] mat_A;
  logic         err_spurious;

  int n_vec = 0;
  int n_err = 0;

  rot_matrix_feeder #(.FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .phase_valid         (phase_valid),
    .phase_ready         (phase_ready),
    .phase_data          (phase_data),
    .cordic_phase_tvalid (cordic_phase_tvalid),
    .cordic_phase_tdata  (cordic_phase_tdata),
    .cordic_dout_tvalid  (cordic_dout_tvalid),
    .cordic_dout_tdata   (cordic_dout_tdata),
    .mat_valid           (mat_valid),
    .mat_ready           (mat_ready),
    .mat_A               (mat_A),
    .err_spurious        (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, settle, and check the credit bound while out of reset
  task automatic tick();
    logic ok;
    @(posedge clk);
    #1;
    if (rst_n) begin
      ok = (int'(dut.inflight_q) + int'(dut.fifo_count)) <= 4;
      chk("credit_bound", 128'(ok), 128'(1'b1));
    end
  endtask

  logic [31:0]  ph_v   [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
  logic [63:0]  dout_v [6] = '{
    {32'h11111111, 32'h00000001}, {32'h22222222, 32'h00000010},
    {32'h33333333, 32'hFFFFFFFF}, {32'h44444444, 32'h7FFFFFFF},
    {32'h55555555, 32'h00000100}, {32'h66666666, 32'h12345678}};
  logic [127:0] mat_v  [6] = '{
    {32'h11111111, 32'hFFFFFFFF, 32'h00000001, 32'h11111111},
    {32'h22222222, 32'hFFFFFFF0, 32'h00000010, 32'h22222222},
    {32'h33333333, 32'h00000001, 32'hFFFFFFFF, 32'h33333333},
    {32'h44444444, 32'h80000001, 32'h7FFFFFFF, 32'h44444444},
    {32'h55555555, 32'hFFFFFF00, 32'h00000100, 32'h55555555},
    {32'h66666666, 32'hEDCBA988, 32'h12345678, 32'h66666666}};
  logic [63:0]  d5_v   [6] = '{
    {32'h0A0A0A0A, 32'h00000002}, {32'h0B0B0B0B, 32'h00000003},
    {32'h0C0C0C0C, 32'h80000000}, {32'h0D0D0D0D, 32'h00010000},
    {32'h0E0E0E0E, 32'hFFFF0000}, {32'h0F0F0F0F, 32'h00000000}};
  logic [127:0] m5_v   [6] = '{
    {32'h0A0A0A0A, 32'hFFFFFFFE, 32'h00000002, 32'h0A0A0A0A},
    {32'h0B0B0B0B, 32'hFFFFFFFD, 32'h00000003, 32'h0B0B0B0B},
    {32'h0C0C0C0C, 32'h7FFFFFFF, 32'h80000000, 32'h0C0C0C0C},
    {32'h0D0D0D0D, 32'hFFFF0000, 32'h00010000, 32'h0D0D0D0D},
    {32'h0E0E0E0E, 32'h00010000, 32'hFFFF0000, 32'h0E0E0E0E},
    {32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'h0F0F0F0F}};

  initial begin
    rst_n              = 1'b0;
    phase_valid        = 1'b0;
    phase_data         = '0;
    cordic_dout_tvalid = 1'b0;
    cordic_dout_tdata  = '0;
    mat_ready          = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      phase_valid        = 1'($urandom);
      phase_data         = $urandom;
      cordic_dout_tvalid = 1'($urandom);
      cordic_dout_tdata  = {$urandom, $urandom};
      mat_ready          = 1'($urandom);
      tick();
      chk("rst_phase_ready", 128'(phase_ready), 128'(1'b0));
      chk("rst_tvalid", 128'(cordic_phase_tvalid), 128'(1'b0));
      chk("rst_tdata", 128'(cordic_phase_tdata), 128'(0));
      chk("rst_mat_valid", 128'(mat_valid), 128'(1'b0));
      chk("rst_mat_A", mat_A, 128'(0));
      chk("rst_err", 128'(err_spurious), 128'(1'b0));
    end
    phase_valid = 1'b0; cordic_dout_tvalid = 1'b0; mat_ready = 1'b0;
    cordic_dout_tdata = '0; phase_data = '0;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 128'(phase_ready), 128'(1'b0));
    tick();
    chk("ready_after_edge", 128'(phase_ready), 128'(1'b1));

    // Single phase through a 20-cycle CORDIC
    phase_valid = 1'b1; phase_data = 32'h00000058;
    tick();
    phase_valid = 1'b0; phase_data = 32'hDEADBEEF;
    chk("single_tvalid", 128'(cordic_phase_tvalid), 128'(1'b1));
    chk("single_tdata", 128'(cordic_phase_tdata), 128'(32'h58));
    chk("single_ready", 128'(phase_ready), 128'(1'b1));
    tick();
    chk("single_tvalid_pulse", 128'(cordic_phase_tvalid), 128'(1'b0));
    chk("single_tdata_hold", 128'(cordic_phase_tdata), 128'(32'h58));
    repeat (18) tick();
    chk("single_not_early", 128'(mat_valid), 128'(1'b0));
    cordic_dout_tvalid = 1'b1; cordic_dout_tdata = {32'h40000000, 32'h00001000};
    tick();
    cordic_dout_tvalid = 1'b0;
    chk("single_mat_valid", 128'(mat_valid), 128'(1'b1));
    chk("single_mat_A", mat_A, {32'h40000000, 32'hFFFFF000, 32'h00001000, 32'h40000000});
    tick();
    chk("single_hold_valid", 128'(mat_valid), 128'(1'b1));
    chk("single_hold_A", mat_A, {32'h40000000, 32'hFFFFF000, 32'h00001000, 32'h40000000});
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("single_popped", 128'(mat_valid), 128'(1'b0));

    // Backpressure: four credits, then stall
    for (int k = 0; k < 4; k++) begin
      phase_valid = 1'b1; phase_data = ph_v[k];
      tick();
      chk("bp_tvalid", 128'(cordic_phase_tvalid), 128'(1'b1));
      chk("bp_tdata", 128'(cordic_phase_tdata), 128'(ph_v[k]));
      chk("bp_ready", 128'(phase_ready), 128'(k < 3));
    end
    phase_data = ph_v[4];
    tick();
    chk("bp_blocked_tvalid", 128'(cordic_phase_tvalid), 128'(1'b0));
    chk("bp_blocked_ready", 128'(phase_ready), 128'(1'b0));
    phase_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cordic_dout_tvalid = 1'b1; cordic_dout_tdata = dout_v[k];
      tick();
      cordic_dout_tvalid = 1'b0;
      chk("bp_full_ready", 128'(phase_ready), 128'(1'b0));
      chk("bp_head", mat_A, mat_v[0]);
    end
    mat_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_valid", 128'(mat_valid), 128'(1'b1));
      chk("bp_drain_A", mat_A, mat_v[k]);
      tick();
    end
    mat_ready = 1'b0;
    chk("bp_drained", 128'(mat_valid), 128'(1'b0));
    chk("bp_ready_back", 128'(phase_ready), 128'(1'b1));
    for (int k = 4; k < 6; k++) begin
      phase_valid = 1'b1; phase_data = ph_v[k];
      tick();
      chk("bp_late_tvalid", 128'(cordic_phase_tvalid), 128'(1'b1));
      chk("bp_late_tdata", 128'(cordic_phase_tdata), 128'(ph_v[k]));
    end
    phase_valid = 1'b0;
    for (int k = 4; k < 6; k++) begin
      cordic_dout_tvalid = 1'b1; cordic_dout_tdata = dout_v[k];
      tick();
    end
    cordic_dout_tvalid = 1'b0;
    mat_ready = 1'b1;
    for (int k = 4; k < 6; k++) begin
      chk("bp_late_valid", 128'(mat_valid), 128'(1'b1));
      chk("bp_late_A", mat_A, mat_v[k]);
      tick();
    end
    mat_ready = 1'b0;
    chk("bp_late_drained", 128'(mat_valid), 128'(1'b0));

    // Saturating negate of the most negative sine
    phase_valid = 1'b1; phase_data = 32'h00000C90;
    tick();
    phase_valid = 1'b0;
    tick();
    cordic_dout_tvalid = 1'b1; cordic_dout_tdata = {32'h00000000, 32'h80000000};
    tick();
    cordic_dout_tvalid = 1'b0;
    chk("sat_m01", 128'(mat_A[95:64]), 128'(32'h7FFFFFFF));
    chk("sat_m10", 128'(mat_A[63:32]), 128'(32'h80000000));
    chk("sat_A", mat_A, {32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000});
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;

    // Credits exhausted, then accept/capture/pop overlapping
    for (int k = 0; k < 4; k++) begin
      phase_valid = 1'b1; phase_data = 32'h51 + 32'(k);
      tick();
    end
    phase_valid = 1'b0;
    chk("ov_ready_low", 128'(phase_ready), 128'(1'b0));
    for (int k = 0; k < 3; k++) begin
      cordic_dout_tvalid = 1'b1; cordic_dout_tdata = d5_v[k];
      tick();
    end
    chk("ov_ready_still_low", 128'(phase_ready), 128'(1'b0));
    chk("ov_head0", mat_A, m5_v[0]);
    cordic_dout_tdata = d5_v[3]; mat_ready = 1'b1;
    tick();
    chk("ov_e1_ready", 128'(phase_ready), 128'(1'b1));
    chk("ov_e1_head", mat_A, m5_v[1]);
    cordic_dout_tvalid = 1'b0; phase_valid = 1'b1; phase_data = 32'h55;
    tick();
    chk("ov_e2_tvalid", 128'(cordic_phase_tvalid), 128'(1'b1));
    chk("ov_e2_tdata", 128'(cordic_phase_tdata), 128'(32'h55));
    chk("ov_e2_ready", 128'(phase_ready), 128'(1'b1));
    chk("ov_e2_head", mat_A, m5_v[2]);
    phase_data = 32'h56; cordic_dout_tvalid = 1'b1; cordic_dout_tdata = d5_v[4];
    tick();
    chk("ov_e3_tvalid", 128'(cordic_phase_tvalid), 128'(1'b1));
    chk("ov_e3_tdata", 128'(cordic_phase_tdata), 128'(32'h56));
    chk("ov_e3_ready", 128'(phase_ready), 128'(1'b1));
    chk("ov_e3_head", mat_A, m5_v[3]);
    phase_valid = 1'b0; mat_ready = 1'b0; cordic_dout_tdata = d5_v[5];
    tick();
    cordic_dout_tvalid = 1'b0;
    mat_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      chk("ov_drain_valid", 128'(mat_valid), 128'(1'b1));
      chk("ov_drain_A", mat_A, m5_v[k]);
      tick();
    end
    mat_ready = 1'b0;
    chk("ov_drained", 128'(mat_valid), 128'(1'b0));

    // Result with nothing outstanding
    chk("sp_err_clear", 128'(err_spurious), 128'(1'b0));
    cordic_dout_tvalid = 1'b1; cordic_dout_tdata = {32'h12121212, 32'h34343434};
    tick();
    cordic_dout_tvalid = 1'b0;
    chk("sp_err_set", 128'(err_spurious), 128'(1'b1));
    chk("sp_dropped", 128'(mat_valid), 128'(1'b0));
    repeat (3) tick();
    chk("sp_err_sticky", 128'(err_spurious), 128'(1'b1));
    chk("sp_still_empty", 128'(mat_valid), 128'(1'b0));

    // Async reset with one matrix buffered and one phase in flight
    phase_valid = 1'b1; phase_data = 32'h61;
    tick();
    phase_valid = 1'b0;
    cordic_dout_tvalid = 1'b1; cordic_dout_tdata = {32'h01010101, 32'h02020202};
    tick();
    cordic_dout_tvalid = 1'b0;
    phase_valid = 1'b1; phase_data = 32'h62;
    tick();
    phase_valid = 1'b0;
    chk("mr_buffered", 128'(mat_valid), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_mat_valid", 128'(mat_valid), 128'(1'b0));
    chk("mr_mat_A", mat_A, 128'(0));
    chk("mr_err", 128'(err_spurious), 128'(1'b0));
    chk("mr_ready", 128'(phase_ready), 128'(1'b0));
    chk("mr_tvalid", 128'(cordic_phase_tvalid), 128'(1'b0));
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_ready_back", 128'(phase_ready), 128'(1'b1));
    cordic_dout_tvalid = 1'b1; cordic_dout_tdata = {32'h03030303, 32'h04040404};
    tick();
    cordic_dout_tvalid = 1'b0;
    chk("mr_stale_err", 128'(err_spurious), 128'(1'b1));
    chk("mr_stale_dropped", 128'(mat_valid), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("mr_err_cleared", 128'(err_spurious), 128'(1'b0));
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
